// File: rtl/hc_gate_tester_if.sv
// hc_gate_tester_if: bundles lab-controller handshake, gate DUT pins and run results
//   start               run request from controller
//   a, b                drive the gate DUT inputs
//   y                   gate DUT outputs
//   busy, done          run in progress / run finished
//   pass, fail          verdict, valid only while done
//   err_cnt             failing vectors in the last run
//   first_vec           {a,b} of the first failing vector
//   first_mask          y ^ expected at the first failing vector
//   master = tester side, slave = controller/DUT side
interface hc_gate_tester_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [8:0] err_cnt;
    logic [7:0] first_vec;
    logic [3:0] first_mask;
    modport master (
        input  start, y,
        output a, b, busy, done, pass, fail, err_cnt, first_vec, first_mask
    );
    modport slave (
        output start, y,
        input  a, b, busy, done, pass, fail, err_cnt, first_vec, first_mask
    );
endinterface

// File: rtl/hc_gate_tester.sv
// hc_gate_tester: exhaustive 256-vector tester for quad 2-input gate chips
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   bus         hc_gate_tester_if.master: start in, a/b out, y in, status/results out
//   GATE_OP     0=AND 1=NAND 2=OR 3=XOR
//   SETTLE_CYC  cycles each vector is held before y is checked (1..255)
module hc_gate_tester #(
    parameter int GATE_OP    = 0,
    parameter int SETTLE_CYC = 4
) (
    input logic             clk,
    input logic             rst,
    hc_gate_tester_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;
    localparam logic [7:0] LAST = 8'(SETTLE_CYC - 1);
    state_t     state, state_n;
    logic [7:0] vec, vec_n, cnt, cnt_n, first_vec_n;
    logic [8:0] err_cnt_n;
    logic [3:0] a_n, b_n, first_mask_n, expv, mism;
    logic       busy_n, done_n, bad;
    always_comb begin
        expv = GATE_OP == 0 ? bus.a & bus.b :
               GATE_OP == 1 ? ~(bus.a & bus.b) :
               GATE_OP == 2 ? bus.a | bus.b : bus.a ^ bus.b;
        mism = bus.y ^ expv;
        // 4-state compare so an undriven or X pin counts as a failure
        bad = bus.y !== expv;
        state_n = state;
        vec_n = vec;
        cnt_n = cnt;
        a_n = bus.a;
        b_n = bus.b;
        busy_n = bus.busy;
        done_n = bus.done;
        err_cnt_n = bus.err_cnt;
        first_vec_n = bus.first_vec;
        first_mask_n = bus.first_mask;
        case (state)
            IDLE, FIN: if (bus.start) begin
                state_n = SETTLE;
                vec_n = '0;
                cnt_n = '0;
                a_n = '0;
                b_n = '0;
                busy_n = 1'b1;
                done_n = 1'b0;
                err_cnt_n = '0;
                first_vec_n = '0;
                first_mask_n = '0;
            end
            SETTLE: begin
                cnt_n = cnt == LAST ? '0 : cnt + 8'd1;
                state_n = cnt == LAST ? CHECK : SETTLE;
            end
            default: begin
                if (bad) begin
                    err_cnt_n = bus.err_cnt + 9'd1;
                    first_vec_n = bus.err_cnt == '0 ? {bus.a, bus.b} : bus.first_vec;
                    first_mask_n = bus.err_cnt == '0 ? mism : bus.first_mask;
                end
                if (vec == 8'hFF) begin
                    state_n = FIN;
                    a_n = '0;
                    b_n = '0;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end else begin
                    state_n = SETTLE;
                    vec_n = vec + 8'd1;
                    {a_n, b_n} = vec + 8'd1;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec <= '0;
            cnt <= '0;
            bus.a <= '0;
            bus.b <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail <= 1'b0;
            bus.err_cnt <= '0;
            bus.first_vec <= '0;
            bus.first_mask <= '0;
        end else begin
            state <= state_n;
            vec <= vec_n;
            cnt <= cnt_n;
            bus.a <= a_n;
            bus.b <= b_n;
            bus.busy <= busy_n;
            bus.done <= done_n;
            bus.pass <= done_n && err_cnt_n == '0;
            bus.fail <= done_n && err_cnt_n != '0;
            bus.err_cnt <= err_cnt_n;
            bus.first_vec <= first_vec_n;
            bus.first_mask <= first_mask_n;
        end
    end
endmodule
